// File: rtl/cmp_pkg.sv
// cmp_pkg: shared state encodings, default width and index-width helper for the serial comparator
package cmp_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int idx_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_w(WIDTH_DEF);

endpackage

// File: rtl/bit_compare_cell.sv
// bit_compare_cell: combinational one-bit magnitude compare of a single operand bit pair
module bit_compare_cell (
    input  logic a_bit_i,
    input  logic b_bit_i,
    output logic eq_o,
    output logic gt_o,
    output logic lt_o
);

    assign eq_o = a_bit_i ~^ b_bit_i;
    assign gt_o = a_bit_i & ~b_bit_i;
    assign lt_o = ~a_bit_i & b_bit_i;

endmodule

// File: rtl/serial_magnitude_comparator_ctrl.sv
// serial_magnitude_comparator_ctrl: MSB-first bit-serial unsigned compare; EARLY_EXIT_EN stops at the first differing bit
module serial_magnitude_comparator_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int IW = idx_w(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             dec_q, dec_d;
    logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
    logic             c_eq, c_gt, c_lt;
    logic             acc, hit, last;

    bit_compare_cell u_cell (
        .a_bit_i (a_q[idx_q]),
        .b_bit_i (b_q[idx_q]),
        .eq_o    (c_eq),
        .gt_o    (c_gt),
        .lt_o    (c_lt)
    );

    assign acc = (state_q == IDLE) && start;
    // only the most significant difference is ever recorded
    assign hit = (state_q == SCAN) && !dec_q && !c_eq;
`ifdef EARLY_EXIT_EN
    assign last = (state_q == SCAN) && ((idx_q == '0) || hit);
`else
    assign last = (state_q == SCAN) && (idx_q == '0);
`endif

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= IW'(WIDTH - 1);
            dec_q   <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            dec_q   <= dec_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    // next state; the unused encoding falls back to IDLE
    always_comb begin
        state_d = (state_q == IDLE) ? (start ? SCAN : IDLE) :
                  (state_q == SCAN) ? (last ? DONE : SCAN) : IDLE;
    end

    // operand capture, bit index walk and sticky result accumulation
    always_comb begin
        a_d   = acc ? a : a_q;
        b_d   = acc ? b : b_q;
        idx_d = acc ? IW'(WIDTH - 1) : ((state_q == SCAN) && !last) ? idx_q - IW'(1) : idx_q;
        dec_d = acc ? 1'b0 : (dec_q | hit);
        gt_d  = acc ? 1'b0 : (gt_q | (hit & c_gt));
        lt_d  = acc ? 1'b0 : (lt_q | (hit & c_lt));
        eq_d  = acc ? 1'b0 : (eq_q | (last & !dec_q & !hit));
    end

    // outputs
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
        eq   = eq_q;
        gt   = gt_q;
        lt   = lt_q;
    end

endmodule

// File: tb/tb_serial_magnitude_comparator_ctrl.sv
// tb_serial_magnitude_comparator_ctrl: scoreboard bench for the serial comparator (either EARLY_EXIT_EN build)
module tb_serial_magnitude_comparator_ctrl;

    typedef struct {
        logic e;
        logic g;
        logic l;
        int   lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] a, b;
    logic       busy, done, eq, gt, lt;
    exp_t       sb[$];
    int         checks = 0;
    int         passed = 0;

    serial_magnitude_comparator_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .eq    (eq),
        .gt    (gt),
        .lt    (lt)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
        exp_t r;
        int   k = -1;
        r.e = (x == y);
        r.g = (x > y);
        r.l = (x < y);
        for (int i = 7; i >= 0; i--) if (x[i] != y[i] && k < 0) k = i;
        r.lat = 9;
`ifdef EARLY_EXIT_EN
        if (k >= 0) r.lat = 1 + (8 - k);
`endif
        return r;
    endfunction

    task automatic push_start(input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        sb.push_back(model(x, y));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({busy, done, eq, gt, lt} !== 5'b0) $display("FAIL reset_outputs: got %b want 00000", {busy, done, eq, gt, lt});
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_equal;
        exp_t e;
        int   n;
        push_start(8'hA5, 8'hA5);
        checks++;
        if (busy !== 1'b1) $display("FAIL eq_busy_rise: got %b want 1", busy);
        else passed++;
        wait_done(1, n);
        e = sb.pop_front();
        checks++;
        if (n !== e.lat || e.lat !== 9) $display("FAIL eq_latency: got %0d want %0d", n, e.lat);
        else passed++;
        checks++;
        if ({eq, gt, lt} !== {e.e, e.g, e.l}) $display("FAIL eq_result: got %b want %b", {eq, gt, lt}, {e.e, e.g, e.l});
        else passed++;
        @(negedge clk);
        checks++;
        if ({busy, done, eq, gt, lt} !== 5'b00100) $display("FAIL eq_after: got %b want 00100", {busy, done, eq, gt, lt});
        else passed++;
    endtask

    task automatic test_msb_diff;
        exp_t e;
        int   n;
        push_start(8'h80, 8'h7F);
        wait_done(1, n);
        e = sb.pop_front();
        checks++;
        if (n !== e.lat) $display("FAIL msb_latency: got %0d want %0d", n, e.lat);
        else passed++;
        checks++;
        if ({eq, gt, lt} !== 3'b010) $display("FAIL msb_result: got %b want 010", {eq, gt, lt});
        else passed++;
        @(negedge clk);
        checks++;
        if ({busy, done, eq, gt, lt} !== 5'b00010) $display("FAIL msb_after: got %b want 00010", {busy, done, eq, gt, lt});
        else passed++;
    endtask

    task automatic test_lsb_diff;
        exp_t e;
        int   n;
        push_start(8'h12, 8'h13);
        wait_done(1, n);
        e = sb.pop_front();
        checks++;
        if (n !== 9) $display("FAIL lsb_latency: got %0d want 9", n);
        else passed++;
        checks++;
        if ({eq, gt, lt} !== {e.e, e.g, e.l}) $display("FAIL lsb_result: got %b want %b", {eq, gt, lt}, {e.e, e.g, e.l});
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        exp_t e;
        int   n;
        int   extra = 0;
        push_start(8'h01, 8'h00);
        @(negedge clk);
        @(negedge clk);
        a = 8'h00;
        b = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(4, n);
        e = sb.pop_front();
        checks++;
        if (n !== e.lat) $display("FAIL ign_latency: got %0d want %0d", n, e.lat);
        else passed++;
        checks++;
        if ({eq, gt, lt} !== 3'b010) $display("FAIL ign_result: got %b want 010", {eq, gt, lt});
        else passed++;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        checks++;
        if (extra !== 0) $display("FAIL ign_no_second_run: got %0d busy cycles want 0", extra);
        else passed++;
    endtask

    task automatic test_mid_reset;
        exp_t e;
        int   n;
        push_start(8'hF0, 8'h0F);
        checks++;
        if (busy !== 1'b1) $display("FAIL rst_busy_before: got %b want 1", busy);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, eq, gt, lt} !== 5'b0) $display("FAIL rst_mid_outputs: got %b want 00000", {busy, done, eq, gt, lt});
        else passed++;
        rst = 1'b0;
        sb = {};
        push_start(8'hC3, 8'hC3);
        wait_done(1, n);
        e = sb.pop_front();
        checks++;
        if (n !== 9) $display("FAIL rst_restart_latency: got %0d want 9", n);
        else passed++;
        checks++;
        if ({eq, gt, lt} !== {e.e, e.g, e.l} || !e.e) $display("FAIL rst_restart_result: got %b want 100", {eq, gt, lt});
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   dn[$];
        @(negedge clk);
        a = 8'h3C;
        b = 8'h3C;
        start = 1'b1;
        repeat (3) sb.push_back(model(8'h3C, 8'h3C));
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dn.push_back(n);
                checks++;
                if (sb.size() == 0) $display("FAIL b2b_extra_done: got done at %0d want none", n);
                else begin
                    e = sb.pop_front();
                    if ({eq, gt, lt} !== {e.e, e.g, e.l}) $display("FAIL b2b_result: got %b want %b", {eq, gt, lt}, {e.e, e.g, e.l});
                    else passed++;
                end
            end
            if (n == 10 || n == 20) begin
                checks++;
                if (busy !== 1'b0) $display("FAIL b2b_gap_%0d: got busy %b want 0", n, busy);
                else passed++;
            end
            if (n == 29) start = 1'b0;
        end
        checks++;
        if (dn.size() != 3 || dn[0] != 9 || dn[1] != 19 || dn[2] != 29)
            $display("FAIL b2b_done_cycles: got %0d pulses want 9,19,29", dn.size());
        else passed++;
    endtask

    task automatic test_random;
        exp_t       e;
        int         n;
        logic [7:0] x, y;
        for (int i = 0; i < 8; i++) begin
            x = 8'($urandom);
            y = (i % 3 == 0) ? x : (i % 3 == 1) ? (x ^ (8'h1 << $urandom_range(7, 0))) : 8'($urandom);
            push_start(x, y);
            wait_done(1, n);
            e = sb.pop_front();
            checks++;
            if (n !== e.lat) $display("FAIL rnd_latency %h/%h: got %0d want %0d", x, y, n, e.lat);
            else passed++;
            checks++;
            if ({eq, gt, lt} !== {e.e, e.g, e.l}) $display("FAIL rnd_result %h/%h: got %b want %b", x, y, {eq, gt, lt}, {e.e, e.g, e.l});
            else passed++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        test_reset;
        test_equal;
        test_msb_diff;
        test_lsb_diff;
        test_ignore_start;
        test_mid_reset;
        test_back_to_back;
        test_random;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
